// File: rtl/hazard_ctrl.sv
`timescale 1ns/1ps
// hazard_ctrl: shadow scoreboard plus stall/flush/forward control for an in-order pipe.
// Build option HAZARD_FWD_EN turns on operand forwarding; without it, readers wait for WB.
module hazard_ctrl #(
    parameter int NSTG     = 5,
    parameter int REG_W    = 5,
    parameter int RDIR_STG = 3,
    parameter int RDIR_PEN = 1,
    parameter int RDY_ALU  = 3,
    parameter int RDY_LD   = 4,
    parameter int CNT_W    = 32
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    id_valid,
    input  logic [REG_W-1:0]        id_rs,
    input  logic [REG_W-1:0]        id_rt,
    input  logic                    id_use_rs,
    input  logic                    id_use_rt,
    input  logic                    id_wen,
    input  logic [REG_W-1:0]        id_wdest,
    input  logic                    id_is_load,
    input  logic                    dmem_wait,
    input  logic                    redirect,
    output logic [NSTG-1:0]         en,
    output logic [NSTG-1:0]         flush,
    output logic [$clog2(NSTG)-1:0] fwd_rs,
    output logic [$clog2(NSTG)-1:0] fwd_rt,
    output logic [CNT_W-1:0]        stall_cnt,
    output logic [CNT_W-1:0]        rdir_cnt
);

    localparam int FW = $clog2(NSTG);

`ifdef HAZARD_FWD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    typedef struct packed {
        logic             v;
        logic             w;
        logic [REG_W-1:0] d;
        logic             ld;
    } ent_t;

    typedef enum logic [1:0] {
        RUN,
        HOLD,
        DRAIN
    } state_t;

    ent_t             sb_q [2:NSTG-1];
    ent_t             sb_d [2:NSTG-1];
    state_t           st_q, st_d;
    logic [3:0]       pen_q, pen_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] rdir_q, rdir_d;

    logic          hit_rs, hit_rt;
    logic          ok_rs, ok_rt;
    logic [FW-1:0] src_rs, src_rt;
    logic          need_rs, need_rt;
    logic          frz, rdir_take, raw, raw_stall, stall_inc;

    assign need_rs   = id_valid & id_use_rs;
    assign need_rt   = id_valid & id_use_rt;
    assign frz       = dmem_wait;
    assign rdir_take = redirect & ~frz;
    assign raw       = (need_rs & hit_rs & ~ok_rs) | (need_rt & hit_rt & ~ok_rt);
    assign raw_stall = raw & ~frz & ~rdir_take;
    assign stall_inc = ~frz & (raw_stall | (st_q == DRAIN));

    assign fwd_rs    = (!RST && FWD_ON && need_rs && hit_rs && ok_rs) ? src_rs : '0;
    assign fwd_rt    = (!RST && FWD_ON && need_rt && hit_rt && ok_rt) ? src_rt : '0;
    assign stall_cnt = stall_q;
    assign rdir_cnt  = rdir_q;

    // Youngest in-flight writer per source; a producer at s sits in latch s+1 when the reader hits EX.
    always_comb begin
        hit_rs = 1'b0;
        hit_rt = 1'b0;
        ok_rs  = 1'b0;
        ok_rt  = 1'b0;
        src_rs = '0;
        src_rt = '0;
        for (int s = NSTG - 1; s >= 2; s--) begin
            if (sb_q[s].v && sb_q[s].w && sb_q[s].d != '0) begin
                if (sb_q[s].d == id_rs) begin
                    hit_rs = 1'b1;
                    ok_rs  = (s == NSTG - 1) ||
                             (FWD_ON && (s + 1 >= (sb_q[s].ld ? RDY_LD : RDY_ALU)));
                    src_rs = (s == NSTG - 1) ? '0 : FW'(s + 1);
                end
                if (sb_q[s].d == id_rt) begin
                    hit_rt = 1'b1;
                    ok_rt  = (s == NSTG - 1) ||
                             (FWD_ON && (s + 1 >= (sb_q[s].ld ? RDY_LD : RDY_ALU)));
                    src_rt = (s == NSTG - 1) ? '0 : FW'(s + 1);
                end
            end
        end
    end

    // Per-stage enable/flush: reset, then freeze, then redirect/drain/RAW.
    always_comb begin
        en    = '1;
        flush = '0;
        if (RST) begin
            en    = '0;
            flush = '1;
        end else if (frz) begin
            en    = '0;
            flush = '0;
        end else begin
            if (raw_stall) begin
                en[1:0]  = 2'b00;
                flush[2] = 1'b1;
            end
            if (st_q == DRAIN) begin
                flush[1] = 1'b1;
            end
            if (rdir_take) begin
                for (int i = 1; i < RDIR_STG; i++) begin
                    flush[i] = 1'b1;
                end
            end
        end
    end

    // Scoreboard shift; flushed latches become bubbles, freeze holds everything.
    always_comb begin
        for (int s = 2; s < NSTG; s++) begin
            sb_d[s] = sb_q[s];
        end
        if (!frz) begin
            sb_d[2].v  = id_valid;
            sb_d[2].w  = id_wen;
            sb_d[2].d  = id_wdest;
            sb_d[2].ld = id_is_load;
            for (int s = 3; s < NSTG; s++) begin
                sb_d[s] = sb_q[s-1];
            end
            for (int s = 2; s < NSTG; s++) begin
                if (flush[s]) begin
                    sb_d[s] = '0;
                end
            end
        end
    end

    // Next state: freeze holds, redirect (re)loads the drain penalty.
    always_comb begin
        st_d  = st_q;
        pen_d = pen_q;
        if (frz) begin
            if (st_q == RUN) begin
                st_d = HOLD;
            end
        end else if (rdir_take) begin
            if (RDIR_PEN > 0) begin
                st_d  = DRAIN;
                pen_d = 4'(RDIR_PEN);
            end else begin
                st_d = RUN;
            end
        end else if (st_q == DRAIN) begin
            pen_d = pen_q - 4'd1;
            if (pen_q <= 4'd1) begin
                st_d = RUN;
            end
        end else begin
            st_d = RUN;
        end
    end

    // Saturating performance counters.
    always_comb begin
        stall_d = stall_q;
        rdir_d  = rdir_q;
        if (stall_inc && stall_q != '1) begin
            stall_d = stall_q + CNT_W'(1);
        end
        if (rdir_take && rdir_q != '1) begin
            rdir_d = rdir_q + CNT_W'(1);
        end
    end

    // Scoreboard registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int s = 2; s < NSTG; s++) begin
                sb_q[s] <= '0;
            end
        end else begin
            for (int s = 2; s < NSTG; s++) begin
                sb_q[s] <= sb_d[s];
            end
        end
    end

    // State, drain counter and performance counter registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            st_q    <= RUN;
            pen_q   <= '0;
            stall_q <= '0;
            rdir_q  <= '0;
        end else begin
            st_q    <= st_d;
            pen_q   <= pen_d;
            stall_q <= stall_d;
            rdir_q  <= rdir_d;
        end
    end

endmodule
